// File: rtl/chebyshev_range_normalizer.sv
// chebyshev_range_normalizer
//
// Brings a signed fixed-point operand into the evaluation range
// [-2^BOUNDARY_BIT_POSITION, 2^BOUNDARY_BIT_POSITION) by shifting it right
// one bit per cycle. The number of shifts is reported as an exponent so
// downstream logic can rescale: original ~= out_data * 2^out_exp.
// Only one operand is in flight at a time.
//
// State table:
//   state | meaning
//   IDLE  | ready for a new operand (in_ready=1)
//   SHIFT | operand out of range, arithmetic shift right each cycle
//   DONE  | result presented (out_valid=1), held until out_ready
//
// Ports:
//   clk          sole clock, rising edge
//   reset        asynchronous, active-high
//   in_data      operand (WL bits, two's complement, I_BITS integer bits)
//   in_valid     operand valid
//   in_ready     block can accept an operand (only in IDLE)
//   out_data     normalized operand
//   out_exp      number of right shifts applied
//   out_inexact  at least one 1-bit was shifted out
//   out_valid    result valid
//   out_ready    downstream accepts the result
module chebyshev_range_normalizer #(
    parameter int WL                    = 16,
    parameter int I_BITS                = 4,
    parameter int BOUNDARY_BIT_POSITION = 1,
    parameter int EXP_WL                = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WL-1:0]     in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WL-1:0]     out_data,
    output logic [EXP_WL-1:0] out_exp,
    output logic              out_inexact,
    output logic              out_valid,
    input  logic              out_ready
);

    // Number of top bits that must all match the sign bit for a value to
    // lie inside [-2^B, 2^B).
    localparam int TOP_W = I_BITS - BOUNDARY_BIT_POSITION;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    logic [WL-1:0]       work;
    logic [EXP_WL-1:0]   exp_cnt;
    logic                inexact;
    logic                in_ready_r;
    logic                out_valid_r;
    logic [WL-1:0]       shifted;

    function automatic logic in_range(input logic [WL-1:0] v);
        logic [TOP_W-1:0] top;
        top = v[WL-1 -: TOP_W];
        return (top == {TOP_W{1'b0}}) || (top == {TOP_W{1'b1}});
    endfunction

    // Arithmetic shift right by one: sign replicated, LSB dropped
    // (truncation toward -inf).
    assign shifted = {work[WL-1], work[WL-1:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            work        <= '0;
            exp_cnt     <= '0;
            inexact     <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work       <= in_data;
                        exp_cnt    <= '0;
                        inexact    <= 1'b0;
                        in_ready_r <= 1'b0;
                        if (in_range(in_data)) begin
                            state       <= DONE;
                            out_valid_r <= 1'b1;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    // A fully shifted value always passes the range test,
                    // so exp_cnt cannot exceed I_BITS-1-B and needs no cap.
                    work    <= shifted;
                    exp_cnt <= exp_cnt + EXP_WL'(1);
                    inexact <= inexact | work[0];
                    if (in_range(shifted)) begin
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_data    = work;
    assign out_exp     = exp_cnt;
    assign out_inexact = inexact;

endmodule

// File: tb/tb_chebyshev_range_normalizer.sv
module tb_chebyshev_range_normalizer;

    localparam int WL     = 16;
    localparam int I_BITS = 4;
    localparam int B      = 1;
    localparam int EXP_WL = 2;
    localparam int BUDGET = 20;

    logic              clk;
    logic              reset;
    logic [WL-1:0]     in_data;
    logic              in_valid;
    logic              in_ready;
    logic [WL-1:0]     out_data;
    logic [EXP_WL-1:0] out_exp;
    logic              out_inexact;
    logic              out_valid;
    logic              out_ready;

    int checks = 0;
    int errors = 0;

    chebyshev_range_normalizer #(
        .WL(WL), .I_BITS(I_BITS), .BOUNDARY_BIT_POSITION(B), .EXP_WL(EXP_WL)
    ) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_exp(out_exp), .out_inexact(out_inexact),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: treat the operand as an integer count of LSBs; the range is
    // [-2^(B+F), 2^(B+F)) with F fraction bits. Halve with floor until inside.
    function automatic void ref_model(input logic [WL-1:0] d,
                                      output logic [WL-1:0] od,
                                      output int k, output bit inex);
        int x;
        int bound;
        int r;
        x     = int'($signed(d));
        bound = 1 << (WL - I_BITS + B);
        k     = 0;
        inex  = 0;
        while (x < -bound || x >= bound) begin
            r = ((x % 2) + 2) % 2;
            if (r != 0) inex = 1;
            x = (x - r) / 2;
            k++;
        end
        od = x[WL-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one operand, waits for the result, then optionally holds
    // out_ready low for 'hold' cycles before completing the handshake.
    task automatic run_op(input logic [WL-1:0] d, input int hold,
                          output logic [WL-1:0] rd, output logic [EXP_WL-1:0] re,
                          output logic rinex, output int lat, output bit timed_out);
        int n;
        timed_out = 0;
        n = 0;
        while (!in_ready && n < BUDGET) begin
            tick();
            n++;
        end
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < BUDGET) begin
            tick();
            lat++;
        end
        if (!out_valid || n >= BUDGET) timed_out = 1;
        rd    = out_data;
        re    = out_exp;
        rinex = out_inexact;
        for (int i = 0; i < hold; i++) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({in_ready, out_valid, out_data, out_exp, out_inexact} !==
            {1'b1, 1'b0, {WL{1'b0}}, {EXP_WL{1'b0}}, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b vld=%b data=%h exp=%0d inex=%b want rdy=1 vld=0 data=0000 exp=0 inex=0",
                     in_ready, out_valid, out_data, out_exp, out_inexact);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_directed();
        logic [WL-1:0] vec [6] = '{16'h1800, 16'h5000, 16'h5001, 16'h8000, 16'hC000, 16'h7FFF};
        logic [WL-1:0] exp_d [6] = '{16'h1800, 16'h1400, 16'h1400, 16'hE000, 16'hE000, 16'h1FFF};
        int            exp_e [6] = '{0, 2, 2, 2, 1, 2};
        bit            exp_i [6] = '{0, 0, 1, 0, 0, 1};
        logic [WL-1:0] rd;
        logic [EXP_WL-1:0] re;
        logic rinex;
        int lat;
        bit to;
        for (int i = 0; i < 6; i++) begin
            run_op(vec[i], 0, rd, re, rinex, lat, to);
            checks++;
            if (to || rd !== exp_d[i] || int'(re) != exp_e[i] || rinex !== exp_i[i]
                || lat != 1 + exp_e[i]) begin
                errors++;
                $display("FAIL directed_%h: got data=%h exp=%0d inex=%b lat=%0d to=%0d want data=%h exp=%0d inex=%0d lat=%0d",
                         vec[i], rd, re, rinex, lat, to, exp_d[i], exp_e[i], exp_i[i], 1 + exp_e[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [WL-1:0] d, rd, md;
        logic [EXP_WL-1:0] re;
        logic rinex;
        int lat, mk;
        bit to, mi;
        for (int i = 0; i < 60; i++) begin
            d = WL'($urandom);
            if (i % 4 == 0) d = {{(I_BITS - B){d[WL-1]}}, d[WL-I_BITS+B-1:0]};
            ref_model(d, md, mk, mi);
            run_op(d, int'($urandom_range(0, 2)), rd, re, rinex, lat, to);
            checks++;
            if (to || rd !== md || int'(re) != mk || rinex !== mi || lat != 1 + mk) begin
                errors++;
                $display("FAIL random_%h: got data=%h exp=%0d inex=%b lat=%0d to=%0d want data=%h exp=%0d inex=%0d lat=%0d",
                         d, rd, re, rinex, lat, to, md, mk, mi, 1 + mk);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        in_data  = 16'h5000;
        in_valid = 1'b1;
        tick();
        in_data = 16'h1800;
        n = 0;
        while (!out_valid && n < BUDGET) begin
            tick();
            n++;
        end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL bp_timeout: got vld=0 want vld=1 within %0d cycles", BUDGET);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 16'h1400
                || out_exp !== 2'd2 || out_inexact !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d: got vld=%b rdy=%b data=%h exp=%0d inex=%b want vld=1 rdy=0 data=1400 exp=2 inex=0",
                         i, out_valid, in_ready, out_data, out_exp, out_inexact);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 16'h1800 || out_exp !== 2'd0) begin
            errors++;
            $display("FAIL b2b_accept: got vld=%b rdy=%b data=%h exp=%0d want vld=1 rdy=0 data=1800 exp=0",
                     out_valid, in_ready, out_data, out_exp);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_shift();
        logic [WL-1:0] rd;
        logic [EXP_WL-1:0] re;
        logic rinex;
        int lat;
        bit to;
        bit stale;
        in_data  = 16'h5000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, out_data, out_exp, out_inexact} !==
            {1'b1, 1'b0, {WL{1'b0}}, {EXP_WL{1'b0}}, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got rdy=%b vld=%b data=%h exp=%0d inex=%b want rdy=1 vld=0 data=0000 exp=0 inex=0",
                     in_ready, out_valid, out_data, out_exp, out_inexact);
        end
        @(negedge clk);
        reset = 1'b0;
        stale = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid !== 1'b0) stale = 1;
        end
        checks++;
        if (stale) begin
            errors++;
            $display("FAIL stale_result: got out_valid pulse after reset want none");
        end
        run_op(16'h1800, 0, rd, re, rinex, lat, to);
        checks++;
        if (to || rd !== 16'h1800 || re !== 2'd0 || rinex !== 1'b0 || lat != 1) begin
            errors++;
            $display("FAIL post_reset_op: got data=%h exp=%0d inex=%b lat=%0d to=%0d want data=1800 exp=0 inex=0 lat=1",
                     rd, re, rinex, lat, to);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid_shift();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
